// File: rtl/game_round_ctrl_pkg.sv
// Shared definitions for the arithmetic-game round sequencer.
//
// Contents:
//   state_t                  - round sequencer states (2-bit encoding)
//   DEFAULT_CLK_HZ           - clock cycles per one-second tick
//   DEFAULT_DEBOUNCE_CYCLES  - stable samples needed before the button level changes
package game_round_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NEWQ = 2'd1,
        ST_WAIT = 2'd2,
        ST_OVER = 2'd3
    } state_t;

    localparam int DEFAULT_CLK_HZ          = 100_000_000;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

endpackage

// File: rtl/btn_debounce.sv
// Start/stop button conditioner: two-flop synchroniser followed by a
// stability counter.
//
// Ports:
//   clock    in   system clock
//   reset    in   asynchronous, active-high reset
//   btn_raw  in   raw, asynchronous button input
//   level    out  debounced button level
//   press    out  one-cycle pulse on the debounced 0->1 edge
module btn_debounce #(
    parameter int STABLE_CYCLES = 1_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] count;

    // The counter tracks how many consecutive synchronised samples have
    // disagreed with the current level; any agreeing sample restarts it.
    // The level flips on the STABLE_CYCLES-th disagreeing sample, and only a
    // flip towards 1 produces a press.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            count <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                count <= '0;
            end else if (count == CNT_LAST) begin
                level <= sync2;
                count <= '0;
                press <= sync2;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/game_round_ctrl.sv
// Round sequencer for the arithmetic game. Debounces the start/stop button,
// pulses the operand LFSR for each new question, times each question in
// whole seconds, and tracks lives and score until the game ends.
//
// Ports:
//   clock         in   system clock
//   reset         in   asynchronous, active-high reset
//   start_btn     in   raw start/stop button
//   answer_valid  in   one-cycle pulse: an answer was submitted
//   answer_right  in   verdict, qualified by answer_valid
//   gen_question  out  one-cycle pulse requesting a new question
//   round_active  out  high while a question is being timed
//   lives         out  thermometer-coded remaining lives
//   score         out  saturating count of correct answers
//   timer_sec     out  seconds remaining on the current question
//   timeout       out  one-cycle pulse when a question expires
//   game_over     out  high while the game-over screen is shown
module game_round_ctrl
    import game_round_ctrl_pkg::*;
#(
    parameter int CLK_HZ           = DEFAULT_CLK_HZ,
    parameter int QUESTION_SECONDS = 10,
    parameter int LIVES            = 3,
    parameter int DEBOUNCE_CYCLES  = DEFAULT_DEBOUNCE_CYCLES,
    parameter int SCORE_W          = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start_btn,
    input  logic               answer_valid,
    input  logic               answer_right,
    output logic               gen_question,
    output logic               round_active,
    output logic [LIVES-1:0]   lives,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         timer_sec,
    output logic               timeout,
    output logic               game_over
);

    localparam int PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);
    localparam logic [3:0] TIMER_LOAD = 4'(QUESTION_SECONDS);

    state_t               state;
    state_t               state_next;
    logic [PRESC_W-1:0]   prescaler;
    logic [PRESC_W-1:0]   prescaler_next;
    logic [3:0]           timer_next;
    logic [LIVES-1:0]     lives_next;
    logic [SCORE_W-1:0]   score_next;
    logic                 press;
    logic                 btn_level;
    logic                 tick;
    logic                 lose_life;

    btn_debounce #(
        .STABLE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clock  (clock),
        .reset  (reset),
        .btn_raw(start_btn),
        .level  (btn_level),
        .press  (press)
    );

    // A press is only ever raised together with the debounced level going high.
    always_ff @(posedge clock) begin
        if (!reset && press) begin
            assert (btn_level);
        end
    end

    assign tick = (prescaler == PRESC_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            prescaler <= '0;
            timer_sec <= '0;
            lives     <= '1;
            score     <= '0;
        end else begin
            state     <= state_next;
            prescaler <= prescaler_next;
            timer_sec <= timer_next;
            lives     <= lives_next;
            score     <= score_next;
        end
    end

    // In WAIT only one event is acted on per cycle: a press beats an answer,
    // and an answer beats the seconds tick, so a suppressed expiry raises no
    // timeout and costs no life. Losing a life drops the highest lit LED,
    // which for a thermometer code is a right shift.
    always_comb begin
        state_next     = state;
        prescaler_next = '0;
        timer_next     = timer_sec;
        lives_next     = lives;
        score_next     = score;
        gen_question   = 1'b0;
        round_active   = 1'b0;
        timeout        = 1'b0;
        game_over      = 1'b0;
        lose_life      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (press) begin
                    lives_next = '1;
                    score_next = '0;
                    state_next = ST_NEWQ;
                end
            end
            ST_NEWQ: begin
                gen_question = 1'b1;
                timer_next   = TIMER_LOAD;
                state_next   = ST_WAIT;
            end
            ST_WAIT: begin
                round_active   = 1'b1;
                prescaler_next = tick ? '0 : prescaler + PRESC_W'(1);
                if (press) begin
                    state_next = ST_OVER;
                end else if (answer_valid) begin
                    if (answer_right) begin
                        if (score != '1) begin
                            score_next = score + SCORE_W'(1);
                        end
                        state_next = ST_NEWQ;
                    end else begin
                        lose_life = 1'b1;
                    end
                end else if (tick) begin
                    if (timer_sec > 4'd1) begin
                        timer_next = timer_sec - 4'd1;
                    end else begin
                        timer_next = '0;
                        timeout    = 1'b1;
                        lose_life  = 1'b1;
                    end
                end
                if (lose_life) begin
                    lives_next = lives >> 1;
                    state_next = ((lives >> 1) == '0) ? ST_OVER : ST_NEWQ;
                end
            end
            ST_OVER: begin
                game_over = 1'b1;
                if (press) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_game_round_ctrl.sv
// Self-checking bench for game_round_ctrl: directed scenarios followed by a
// random phase, all compared cycle by cycle against a behavioural model.
module tb_game_round_ctrl;

    localparam int CLK_HZ    = 10;
    localparam int QS        = 3;
    localparam int DEB       = 4;
    localparam int LIVES     = 3;
    localparam int SCORE_W   = 2;
    localparam int SCORE_MAX = (1 << SCORE_W) - 1;

    localparam int M_IDLE = 0;
    localparam int M_NEWQ = 1;
    localparam int M_WAIT = 2;
    localparam int M_OVER = 3;

    logic               clock = 1'b0;
    logic               reset;
    logic               start_btn;
    logic               answer_valid;
    logic               answer_right;
    logic               gen_question;
    logic               round_active;
    logic [LIVES-1:0]   lives;
    logic [SCORE_W-1:0] score;
    logic [3:0]         timer_sec;
    logic               timeout;
    logic               game_over;

    game_round_ctrl #(
        .CLK_HZ          (CLK_HZ),
        .QUESTION_SECONDS(QS),
        .LIVES           (LIVES),
        .DEBOUNCE_CYCLES (DEB),
        .SCORE_W         (SCORE_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start_btn   (start_btn),
        .answer_valid(answer_valid),
        .answer_right(answer_right),
        .gen_question(gen_question),
        .round_active(round_active),
        .lives       (lives),
        .score       (score),
        .timer_sec   (timer_sec),
        .timeout     (timeout),
        .game_over   (game_over)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Behavioural model: game mode, life count, score, cycles spent on the
    // current question, and the button expressed as a sample history.
    int m_mode;
    int m_lives;
    int m_score;
    int m_timer_hold;
    int m_wc;
    bit m_level;
    bit m_press;
    bit m_pipe[$];
    bit m_window[$];

    int gen_seen;
    int timeout_seen;
    int last_timer;
    int last_lives;
    int last_score;
    bit last_gen;
    bit last_active;
    bit last_timeout;
    bit last_over;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, observed, expected);
        end
    endtask

    function automatic void modelReset();
        m_mode       = M_IDLE;
        m_lives      = LIVES;
        m_score      = 0;
        m_timer_hold = 0;
        m_wc         = 0;
        m_level      = 1'b0;
        m_press      = 1'b0;
        m_pipe       = {1'b0, 1'b0};
        m_window     = {};
    endfunction

    function automatic int modelTimer();
        return (m_mode == M_WAIT) ? QS - m_wc / CLK_HZ : m_timer_hold;
    endfunction

    function automatic bit modelExpiresNow();
        return (m_mode == M_WAIT) && (m_wc + 1 == QS * CLK_HZ);
    endfunction

    function automatic void modelLoseLife();
        m_lives--;
        m_mode = (m_lives == 0) ? M_OVER : M_NEWQ;
    endfunction

    function automatic void modelEdge(input bit btn, input bit av, input bit ar);
        bit sample;
        bit all_differ;
        case (m_mode)
            M_IDLE: if (m_press) begin
                m_lives = LIVES;
                m_score = 0;
                m_mode  = M_NEWQ;
            end
            M_NEWQ: begin
                m_mode = M_WAIT;
                m_wc   = 0;
            end
            M_WAIT: begin
                if (m_press) begin
                    m_timer_hold = modelTimer();
                    m_mode = M_OVER;
                end else if (av && ar) begin
                    m_timer_hold = modelTimer();
                    m_score = (m_score < SCORE_MAX) ? m_score + 1 : SCORE_MAX;
                    m_mode = M_NEWQ;
                end else if (av) begin
                    m_timer_hold = modelTimer();
                    modelLoseLife();
                end else if (modelExpiresNow()) begin
                    m_timer_hold = 0;
                    modelLoseLife();
                end else begin
                    m_wc++;
                end
            end
            default: if (m_press) m_mode = M_IDLE;
        endcase
        sample = m_pipe.pop_front();
        m_pipe.push_back(btn);
        m_window.push_back(sample);
        if (m_window.size() > DEB) void'(m_window.pop_front());
        m_press = 1'b0;
        if (m_window.size() == DEB) begin
            all_differ = 1'b1;
            foreach (m_window[i]) if (m_window[i] == m_level) all_differ = 1'b0;
            if (all_differ) begin
                m_level = ~m_level;
                m_press = m_level;
            end
        end
    endfunction

    task automatic compareAll();
        bit exp_timeout;
        exp_timeout = modelExpiresNow() && !m_press && !answer_valid;
        checkOutput("gen_question", 32'(gen_question), 32'(m_mode == M_NEWQ));
        checkOutput("round_active", 32'(round_active), 32'(m_mode == M_WAIT));
        checkOutput("game_over", 32'(game_over), 32'(m_mode == M_OVER));
        checkOutput("timeout", 32'(timeout), 32'(exp_timeout));
        checkOutput("lives", 32'(lives), 32'((1 << m_lives) - 1));
        checkOutput("score", 32'(score), 32'(m_score));
        checkOutput("timer_sec", 32'(timer_sec), 32'(modelTimer()));
    endtask

    task automatic applyStimulus(input bit btn, input bit av, input bit ar);
        @(negedge clock);
        start_btn    = btn;
        answer_valid = av;
        answer_right = ar;
        #1;
        last_gen     = gen_question;
        last_active  = round_active;
        last_timeout = timeout;
        last_over    = game_over;
        last_timer   = int'(timer_sec);
        last_lives   = int'(lives);
        last_score   = int'(score);
        if (gen_question) gen_seen++;
        if (timeout) timeout_seen++;
        compareAll();
        @(posedge clock);
        modelEdge(btn, av, ar);
    endtask

    task automatic pressButton();
        for (int i = 0; i < DEB + 3; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < DEB + 3; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    task automatic pressWithAnswer(input bit ar);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_press) begin
                applyStimulus(1'b1, 1'b1, ar);
                found = 1'b1;
            end else begin
                applyStimulus(1'b1, 1'b0, 1'b0);
            end
        end
        checkOutput("press_with_answer_seen", 32'(found), 32'd1);
        for (int i = 0; i < DEB + 3; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    task automatic pulseReset();
        reset        = 1'b1;
        start_btn    = 1'b0;
        answer_valid = 1'b0;
        answer_right = 1'b0;
        #1;
        checkOutput("rst_gen_question", 32'(gen_question), 32'd0);
        checkOutput("rst_round_active", 32'(round_active), 32'd0);
        checkOutput("rst_timeout", 32'(timeout), 32'd0);
        checkOutput("rst_game_over", 32'(game_over), 32'd0);
        checkOutput("rst_lives", 32'(lives), 32'b111);
        checkOutput("rst_score", 32'(score), 32'd0);
        checkOutput("rst_timer_sec", 32'(timer_sec), 32'd0);
        @(posedge clock);
        @(posedge clock);
        #2;
        reset = 1'b0;
        modelReset();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit found;
        bit rbtn;
        int hold;

        pulseReset();

        // Bouncing button: only the final steady high may count as a press.
        gen_seen = 0;
        for (int i = 0; i < 20; i++) applyStimulus(((i / 2) % 2) == 0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("bounce_gen_count", 32'(gen_seen), 32'd1);
        checkOutput("bounce_active", 32'(last_active), 32'd1);
        checkOutput("bounce_timer", 32'(last_timer), 32'd3);
        for (int i = 0; i < DEB + 2; i++) applyStimulus(1'b0, 1'b0, 1'b0);

        // Correct answers, the fourth one hitting score saturation.
        gen_seen = 0;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0);
            if (k == 2) begin
                checkOutput("three_right_score", 32'(last_score), 32'd3);
                checkOutput("three_right_gen", 32'(gen_seen), 32'd3);
            end
        end
        checkOutput("saturated_score", 32'(last_score), 32'd3);
        checkOutput("right_lives", 32'(last_lives), 32'b111);

        // Let the question expire.
        gen_seen = 0;
        timeout_seen = 0;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            found = last_timeout;
        end
        checkOutput("timeout_seen", 32'(timeout_seen), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("expiry_lives", 32'(last_lives), 32'b011);
        checkOutput("expiry_newq_gen", 32'(last_gen), 32'd1);
        checkOutput("expiry_newq_timer", 32'(last_timer), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("expiry_reload_timer", 32'(last_timer), 32'd3);

        // Wrong answers until the game is over.
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("wrong1_lives", 32'(last_lives), 32'b001);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("wrong_last_over", 32'(last_over), 32'd1);
        checkOutput("wrong_last_lives", 32'(last_lives), 32'd0);
        gen_seen = 0;
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'($urandom_range(0, 1)));
        checkOutput("over_no_gen", 32'(gen_seen), 32'd0);
        checkOutput("over_score_held", 32'(last_score), 32'd3);

        // Back to IDLE, then a fresh game.
        pressButton();
        checkOutput("idle_after_over", 32'(last_over), 32'd0);
        pressButton();
        checkOutput("new_game_lives", 32'(last_lives), 32'b111);
        checkOutput("new_game_score", 32'(last_score), 32'd0);

        // Correct answer landing on the expiry cycle.
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (modelExpiresNow()) begin
                applyStimulus(1'b0, 1'b1, 1'b1);
                found = 1'b1;
            end else begin
                applyStimulus(1'b0, 1'b0, 1'b0);
            end
        end
        checkOutput("collision_reached", 32'(found), 32'd1);
        checkOutput("collision_no_timeout", 32'(last_timeout), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("collision_score", 32'(last_score), 32'd1);
        checkOutput("collision_lives", 32'(last_lives), 32'b111);

        // Press coinciding with a correct answer: quit wins.
        pressWithAnswer(1'b1);
        checkOutput("press_answer_over", 32'(last_over), 32'd1);
        checkOutput("press_answer_score", 32'(last_score), 32'd1);

        // Reset in the middle of a question.
        pressButton();
        pressButton();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (m_mode == M_WAIT && modelTimer() == 2) found = 1'b1;
            else applyStimulus(1'b0, 1'b0, 1'b0);
        end
        checkOutput("pre_reset_reached", 32'(found), 32'd1);
        @(negedge clock);
        checkOutput("pre_reset_timer", 32'(timer_sec), 32'd2);
        #2;
        pulseReset();
        pressButton();
        checkOutput("post_reset_score", 32'(last_score), 32'd0);
        checkOutput("post_reset_active", 32'(last_active), 32'd1);

        // Random phase.
        rbtn = 1'b0;
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                rbtn = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 10);
            end
            hold--;
            applyStimulus(rbtn, ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/game_round_ctrl.md
Name: game_round_ctrl

Overview:
- Round sequencer for the arithmetic game; sits between the start button, answer_check and the operand LFSR.
- Debounces the start/stop button, issues one-cycle "generate question" pulses to the LFSR, and runs the per-question countdown.
- Consumes answer verdicts, keeps lives and score, and raises game_over. The top level uses game_over to select the game-over screen.

Parameters:
- CLK_HZ, 100_000_000, clock cycles per second tick.
- QUESTION_SECONDS, 10, countdown per question (1..15).
- LIVES, 3, starting lives; also the width of the lives port (1..8).
- DEBOUNCE_CYCLES, 1_000_000, number of cycles the synchronised button must be stable.
- SCORE_W, 4, score width.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start_btn  in  1  raw start/stop button, asynchronous
- answer_valid  in  1  one-cycle pulse: the user submitted an answer (new_ques)
- answer_right  in  1  verdict, qualified by answer_valid
- gen_question  out  1  one-cycle pulse to the LFSR and keyboard FSM clear
- round_active  out  1  high while a question is being timed
- lives  out  LIVES  thermometer code for the LEDs
- score  out  SCORE_W  correct answers, saturating
- timer_sec  out  4  seconds remaining on the current question
- timeout  out  1  one-cycle pulse: the question expired
- game_over  out  1  level, high in state OVER

Behaviour:
- Reset values (asynchronous):
  - state IDLE; lives all ones; score 0; timer_sec 0.
  - gen_question, timeout, round_active and game_over all 0.
  - Debouncer level 0, counters 0.
- Debounce (btn_debounce):
  - Two-flop synchroniser, then a stability counter.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive equal samples that differ from the current level.
  - press is a one-cycle pulse on the debounced 0->1 edge. Release generates nothing.
- States: IDLE, NEWQ, WAIT, OVER.
- IDLE:
  - On press: load lives all ones and score 0, then go to NEWQ.
- NEWQ (exactly 1 cycle):
  - gen_question=1.
  - timer_sec <= QUESTION_SECONDS; prescaler <= 0.
  - Next state is WAIT.
- WAIT:
  - round_active=1.
  - The prescaler counts 0..CLK_HZ-1; a tick occurs when it reaches CLK_HZ-1.
  - On a tick with timer_sec>1: timer_sec decrements.
  - On a tick with timer_sec==1 (expiry): timer_sec <= 0, timeout=1 that cycle, and a life is lost.
  - answer_valid with answer_right=1: score += 1, saturating at all ones; go to NEWQ.
  - answer_valid with answer_right=0: a life is lost.
  - Life loss: clear the highest set bit of lives. If lives becomes 0, go to OVER, else go to NEWQ.
  - press in WAIT: quit; go to OVER. lives and score hold.
- Priority in the same WAIT cycle: press > answer_valid > expiry.
  - A suppressed expiry produces no timeout pulse.
  - A suppressed answer does not change score or lives.
- OVER:
  - game_over=1; score, lives and timer_sec hold.
  - press goes to IDLE. score and lives stay visible until the next IDLE press.
- Outside WAIT:
  - answer_valid is ignored.
  - The prescaler is held at 0.
- Latency:
  - press to gen_question: 1 cycle, i.e. NEWQ is the state in the cycle after press.
  - A wrong answer on the last life: game_over asserts the next cycle.
- Reset asserted mid-round returns immediately to the reset values listed above; no pulse is emitted.

Decomposition:
- Shared package:
  - state encoding constants ST_IDLE, ST_NEWQ, ST_WAIT, ST_OVER (2-bit);
  - the default timing constants (CLK_HZ, DEBOUNCE_CYCLES).
- Sub-module btn_debounce (params STABLE_CYCLES; ports clock, reset, btn_raw, level, press).
- The FSM, timer and lives/score logic stay in game_round_ctrl.

Test Plan (all scenarios use CLK_HZ=10, QUESTION_SECONDS=3, DEBOUNCE_CYCLES=4, LIVES=3):
- Bounce: toggle start_btn every 2 cycles for 20 cycles, then hold high 10 cycles -> exactly one press, one gen_question pulse, state WAIT, timer_sec=3.
- Three correct answers, each answer_valid with right=1 -> score=3, lives=3'b111, 3 further gen_question pulses; with SCORE_W=2 a 4th correct answer keeps score=3.
- No answer for 30 cycles -> timer_sec steps 3,2,1 at 10-cycle ticks; timeout pulse; lives=3'b011; new gen_question; timer_sec=3.
- Three wrong answers -> lives 011, 001, 000; game_over=1 the cycle after the third; no gen_question afterwards; answer_valid in OVER is ignored.
- answer_valid(right=1) in the same cycle as expiry -> score+1, no timeout pulse, lives unchanged; press coinciding with answer_valid -> OVER, score unchanged.
- Assert reset while in WAIT with timer_sec=2 -> all outputs return to reset values asynchronously; after reset release, a press starts a fresh game with score=0.
